// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and FIFO pointer synchronisers.
// Values are carried in 32-bit containers; callers zero-extend and truncate.
package gray_pkg;

    function automatic logic [31:0] max_val(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits above w are masked off so they cannot leak into the prefix XOR.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & max_val(w);
        b = '0;
        b[31] = gm[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    always_comb begin
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
    end

endmodule

// File: rtl/gray_counter_n.sv
// Registered up/down counter with binary and Gray outputs, parallel load
// (binary or Gray), wrap/saturate mode and a registered terminal-count flag.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gout,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ld_bin;
    logic [WIDTH-1:0] nxt;
    logic             tc_nxt;

    gray2bin_n #(.WIDTH(WIDTH)) u_ld_conv (
        .g (ld_val),
        .b (ld_bin)
    );

    // Next-state: load beats count, count beats hold.
    always_comb begin
        nxt    = cnt;
        tc_nxt = 1'b0;
        if (load) begin
            nxt = load_gray ? ld_bin : ld_val;
        end else if (en) begin
            if (up) begin
                if (cnt == MAXV) begin
                    tc_nxt = 1'b1;
                    nxt    = WRAP ? '0 : cnt;
                end else begin
                    nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    tc_nxt = 1'b1;
                    nxt    = WRAP ? MAXV : cnt;
                end else begin
                    nxt = cnt - 1'b1;
                end
            end
        end
    end

    // Gray is registered from the same next value so gout never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            gout <= '0;
            tc   <= 1'b0;
        end else begin
            cnt  <= nxt;
            gout <= WIDTH'(bin2gray(32'(nxt)));
            tc   <= tc_nxt;
        end
    end

    assign bin = cnt;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: a wrapping and a saturating 4-bit instance share
// stimulus and are compared against an integer reference model.
module tb_gray_counter_n;

    localparam int W = 4;
    localparam int M = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic         load_gray = 1'b0;
    logic [W-1:0] ld_val = '0;
    logic [W-1:0] bin_w, gout_w, bin_s, gout_s;
    logic         tc_w, tc_s;

    int n_cmp = 0;
    int n_bad = 0;
    int mcnt [2];
    int mtc  [2];

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(W), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .ld_val(ld_val),
        .bin(bin_w), .gout(gout_w), .tc(tc_w)
    );

    gray_counter_n #(.WIDTH(W), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .ld_val(ld_val),
        .bin(bin_s), .gout(gout_s), .tc(tc_s)
    );

    typedef struct {
        logic         load;
        logic         load_gray;
        logic         en;
        logic         up;
        logic [W-1:0] ld_val;
        logic [W-1:0] exp_bin;
        logic [W-1:0] exp_gout;
        logic         exp_tc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code matches.
    function automatic int gray_decode(input int g);
        for (int i = 0; i <= M; i++) begin
            if (gray_of(i) == g) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int nv;
            int nt;
            nv = mcnt[k];
            nt = 0;
            if (load) begin
                nv = load_gray ? gray_decode(int'(ld_val)) : int'(ld_val);
            end else if (en) begin
                if (up) begin
                    nt = (mcnt[k] == M) ? 1 : 0;
                    nv = (k == 0) ? (mcnt[k] + 1) % (M + 1)
                                  : ((mcnt[k] + 1 > M) ? M : mcnt[k] + 1);
                end else begin
                    nt = (mcnt[k] == 0) ? 1 : 0;
                    nv = (k == 0) ? (mcnt[k] + M) % (M + 1)
                                  : ((mcnt[k] - 1 < 0) ? 0 : mcnt[k] - 1);
                end
            end
            mcnt[k] = nv;
            mtc[k]  = nt;
        end
    endtask

    task automatic check_model();
        check("w_bin",  32'(bin_w),  32'(mcnt[0]));
        check("w_gout", 32'(gout_w), 32'(gray_of(mcnt[0])));
        check("w_tc",   32'(tc_w),   32'(mtc[0]));
        check("s_bin",  32'(bin_s),  32'(mcnt[1]));
        check("s_gout", 32'(gout_s), 32'(gray_of(mcnt[1])));
        check("s_tc",   32'(tc_s),   32'(mtc[1]));
    endtask

    // Inputs are stable here (set after the previous edge); sample 1 ns after.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Called 1 ns after an edge: reset lands 3 ns after the edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_bin_w",  32'(bin_w),  32'd0);
        check("rst_gout_w", 32'(gout_w), 32'd0);
        check("rst_tc_w",   32'(tc_w),   32'd0);
        check("rst_bin_s",  32'(bin_s),  32'd0);
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mtc[k]  = 0;
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs [10];
        logic [W-1:0] gseq [16];
        logic [W-1:0] prev;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1111, 4'b1000, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1110, 4'b1001, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 4'b1001, 4'b1101, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b1111, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1010, 4'b1111, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'b1011, 4'b1110, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1010, 4'b1111, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1000, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0};

        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Reset between edges, then hold with en = 0.
        #3 rst_n = 1'b0;
        #1;
        check("init_bin",  32'(bin_w),  32'd0);
        check("init_gout", 32'(gout_w), 32'd0);
        check("init_tc",   32'(tc_w),   32'd0);
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mtc[k]  = 0;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();

        // Full up sweep with one-bit-change check.
        en = 1'b1;
        up = 1'b1;
        prev = gout_w;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("sweep_gout", 32'(gout_w), 32'(gseq[k % 16]));
            check("sweep_tc",   32'(tc_w),   (k == 16) ? 32'd1 : 32'd0);
            check("sweep_1bit", 32'($countones(gout_w ^ prev)), 32'd1);
            prev = gout_w;
        end

        // Directed table on the wrapping instance, starting from zero.
        async_reset();
        for (int i = 0; i < 10; i++) begin
            load      = vecs[i].load;
            load_gray = vecs[i].load_gray;
            en        = vecs[i].en;
            up        = vecs[i].up;
            ld_val    = vecs[i].ld_val;
            step();
            check($sformatf("vec%0d_bin", i),  32'(bin_w),  32'(vecs[i].exp_bin));
            check($sformatf("vec%0d_gout", i), 32'(gout_w), 32'(vecs[i].exp_gout));
            check($sformatf("vec%0d_tc", i),   32'(tc_w),   32'(vecs[i].exp_tc));
        end

        // Saturation on the non-wrapping instance.
        load = 1'b1; load_gray = 1'b0; ld_val = 4'b1110; en = 1'b1; up = 1'b1;
        step();
        load = 1'b0;
        step();
        check("sat_first_bin", 32'(bin_s), 32'hF);
        check("sat_first_tc",  32'(tc_s),  32'd0);
        for (int k = 0; k < 3; k++) begin
            prev = gout_s;
            step();
            check("sat_hold_bin",  32'(bin_s),  32'hF);
            check("sat_hold_gout", 32'(gout_s), 32'h8);
            check("sat_hold_tc",   32'(tc_s),   32'd1);
            check("sat_hold_0bit", 32'($countones(gout_s ^ prev)), 32'd0);
        end
        up = 1'b0;
        step();
        check("sat_down_bin", 32'(bin_s), 32'hE);
        check("sat_down_tc",  32'(tc_s),  32'd0);

        // Reset mid-count at 0110, then resume from zero.
        async_reset();
        up = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("pre_rst_bin", 32'(bin_w), 32'h6);
        async_reset();
        step();
        check("resume1_bin", 32'(bin_w), 32'h1);
        step();
        check("resume2_bin", 32'(bin_w), 32'h2);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic was_count;
            load      = ($urandom_range(0, 9) == 0);
            load_gray = $urandom_range(0, 1) == 1;
            en        = $urandom_range(0, 3) != 0;
            up        = $urandom_range(0, 1) == 1;
            ld_val    = W'($urandom);
            was_count = !load && en;
            prev      = gout_w;
            step();
            if (was_count) check("rand_1bit", 32'($countones(gout_w ^ prev)), 32'd1);
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised, registered up/down counter that holds its state in binary and presents both binary and Gray-coded outputs.
- Generalises the team's 4-bit binary-to-Gray converter to WIDTH bits.
- Adds enable, direction, parallel load (binary or Gray), wrap/saturate mode and a terminal-count flag.
- Used as a pointer source for clock-domain-crossing FIFOs and as a glitch-free position encoder.

Parameters:
- WIDTH, 4, counter/code width in bits; legal range 2..32.
- WRAP, 1, 1 = wrap at terminal value; 0 = saturate (hold) at terminal value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_gray  input  1  1 = ld_val is Gray-coded; 0 = ld_val is binary.
- ld_val  input  WIDTH  load value.
- bin  output  WIDTH  registered binary count.
- gout  output  WIDTH  registered Gray count.
- tc  output  1  registered terminal-count flag.

Behaviour:
- Reset: while rst_n = 0, bin = 0, gout = 0 and tc = 0, taking effect immediately without a clock edge. The first update happens on the first rising clk edge after rst_n rises.
- State: the binary register cnt. The gout register is written on the same edge as cnt.
- Gray invariant: at every edge gout <= next ^ (next >> 1). Hence gout == bin ^ (bin >> 1) always holds. gout is driven straight from flops, never from combinational logic.
- Priority per edge: load > en > hold.
- Load (load = 1, regardless of en):
  - load_gray = 0: next = ld_val.
  - load_gray = 1: next = gray2bin(ld_val), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
  - tc <= 0.
- Count (load = 0, en = 1):
  - up = 1, cnt < 2^WIDTH-1: next = cnt + 1.
  - up = 1, cnt = 2^WIDTH-1: next = 0 if WRAP = 1; next = cnt if WRAP = 0.
  - up = 0, cnt > 0: next = cnt - 1.
  - up = 0, cnt = 0: next = 2^WIDTH-1 if WRAP = 1; next = 0 if WRAP = 0.
  - Arithmetic is modulo 2^WIDTH. No carry-out port.
- tc:
  - Registered. tc <= 1 on an edge where load = 0, en = 1, and cnt is at the terminal value for the current direction (max when up, 0 when down). Otherwise tc <= 0.
  - WRAP = 1: a one-cycle pulse coincident with bin showing the wrapped value.
  - WRAP = 0: stays high every cycle the counter is enabled and held at the terminal value.
- Hold (load = 0, en = 0): cnt, gout unchanged; tc <= 0.
- Direction change: up may change on any cycle and takes effect on the next edge. No dead cycles.
- Latency: one clk from input sampled to bin/gout/tc updated.
- Step property: any enabled count step changes exactly one bit of gout. Saturated hold changes zero bits. Loads may change any number of bits.
- Reset mid-operation: asynchronous clear wins over any load/en in flight. No partial update is ever visible.

Decomposition:
- Package gray_pkg:
  - Functions bin2gray(WIDTH) and gray2bin(WIDTH), shared with the FIFO pointer-sync logic.
  - localparam-style helper for the max value, (1 << WIDTH) - 1.
- One combinational sub-module, gray2bin_n (parameter WIDTH): prefix-XOR converter used on the load path. Also reused by the FIFO read side.
- The counter core stays in gray_counter_n.

Test Plan:
- Reset: assert rst_n = 0 between clock edges -> bin = 0000, gout = 0000, tc = 0 immediately. Release, en = 0 -> all hold at 0.
- Full up sweep, WIDTH = 4, WRAP = 1, en = 1, up = 1, 17 edges:
  - gout steps 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - tc = 1 exactly on the cycle bin returns to 0000.
  - Checker: popcount(gout ^ gout_prev) == 1 on every step.
- Down wrap: from reset, en = 1, up = 0 -> bin = 1111, gout = 1000, tc = 1 one cycle. Next edge -> bin = 1110, gout = 1001, tc = 0.
- Loads:
  - load = 1, load_gray = 1, ld_val = 1101, en = 1 simultaneously -> bin = 1001, gout = 1101, tc = 0 (load wins over count).
  - load_gray = 0, ld_val = 1010 -> bin = 1010, gout = 1111.
- Saturate, WRAP = 0: load 1110, en = 1, up = 1 -> bin = 1111, tc = 0. Next 3 edges -> bin stays 1111, gout stays 1000, tc = 1 each cycle. Then up = 0 -> bin = 1110, tc = 0.
- Reset mid-count: counting up at bin = 0110, pull rst_n low 3 ns after an edge -> bin/gout/tc = 0 before the next edge. Release -> count resumes 0001, 0010, ...
